mul_div_unit: RTL and testbench

HI/LO multiply–divide unit that responds to the EXE stage's multiply/divide requests. EXE presents operands, a one-hot operation code, and a read request for mfhi/mflo. The unit runs a 2-cycle multiply or a 32-iteration restoring divide. It drives the EXE `ready` term and commits HI/LO only when the instruction leaves EXE. It sits beside the EXE stage and is cleared by the WB flush (`wb_ClrStpJmp`).

---
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 tb/tb_mul_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit beside the EXE stage: 2-cycle multiply, 32-step restoring divide,
// results committed to HI/LO only when the instruction leaves EXE.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_valid_in,
    input  logic [5:0]  md_op_in,
    input  logic        md_read_request_in,
    input  logic        md_read_hi_in,
    input  logic [31:0] md_src0_in,
    input  logic [31:0] md_src1_in,
    input  logic        md_fire_in,
    input  logic        md_flush_in,
    output logic        md_ready_out,
    output logic [31:0] md_rdata_out,
    output logic        md_busy_out
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    // Op bits: 5 mthi, 4 mtlo, 3 mult, 2 multu, 1 div, 0 divu
    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        signed_q, signed_d;

    logic        md_req;
    logic        start;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag;
    logic [63:0] mul_a, mul_b, product;
    logic [32:0] div_tmp;
    logic [31:0] div_sub, rem_next, quo_next;
    logic        div_ge, q_neg, r_neg;

    assign md_req = |md_op_in[3:0];
    assign start  = (state_q == StIdle) & md_valid_in & md_req & ~md_flush_in;

    // Dividend magnitude is loaded straight into the quotient shift register at start.
    assign a_mag_in = (md_op_in[1] & md_src0_in[31]) ? (32'd0 - md_src0_in) : md_src0_in;
    assign b_mag    = (signed_q & b_q[31]) ? (32'd0 - b_q) : b_q;

    // Low 64 bits of a 64x64 product of extended operands give the signed or unsigned result.
    assign mul_a   = {{32{signed_q & a_q[31]}}, a_q};
    assign mul_b   = {{32{signed_q & b_q[31]}}, b_q};
    assign product = mul_a * mul_b;

    // One restoring step: res_hi holds the partial remainder, res_lo the dividend/quotient.
    assign div_tmp  = {res_hi_q, res_lo_q[31]};
    assign div_ge   = div_tmp >= {1'b0, b_mag};
    assign div_sub  = div_tmp[31:0] - b_mag;
    assign rem_next = div_ge ? div_sub : div_tmp[31:0];
    assign quo_next = {res_lo_q[30:0], div_ge};
    assign q_neg    = signed_q & (a_q[31] ^ b_q[31]);
    assign r_neg    = signed_q & a_q[31];

    assign md_ready_out = (state_q == StDone) |
                          ((state_q == StIdle) & ~(md_valid_in & md_req));
    assign md_busy_out  = (state_q != StIdle);
    // Read request only qualifies EXE; the data path is a plain select.
    assign md_rdata_out = (md_read_hi_in | (md_read_request_in & 1'b0)) ? hi_q : lo_q;

    // Next-state and datapath updates; flush overrides fire and start.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        if (md_flush_in) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_d      = md_src0_in;
                        b_d      = md_src1_in;
                        signed_d = md_op_in[3] | md_op_in[1];
                        if (md_op_in[3] | md_op_in[2]) begin
                            state_d = StMul;
                        end else begin
                            state_d  = StDiv;
                            cnt_d    = 5'd0;
                            res_hi_d = 32'd0;
                            res_lo_d = a_mag_in;
                        end
                    end
                    if (md_fire_in & md_op_in[5]) hi_d = md_src0_in;
                    if (md_fire_in & md_op_in[4]) lo_d = md_src0_in;
                end
                StMul: begin
                    res_hi_d = product[63:32];
                    res_lo_d = product[31:0];
                    state_d  = StDone;
                end
                StDiv: begin
                    res_hi_d = rem_next;
                    res_lo_d = quo_next;
                    cnt_d    = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                        cnt_d   = 5'd0;
                        if (b_q == 32'd0) begin
                            res_lo_d = 32'hFFFF_FFFF;
                            res_hi_d = a_q;
                        end else begin
                            res_lo_d = q_neg ? (32'd0 - quo_next) : quo_next;
                            res_hi_d = r_neg ? (32'd0 - rem_next) : rem_next;
                        end
                    end
                end
                StDone: begin
                    if (md_fire_in) begin
                        hi_d    = res_hi_q;
                        lo_d    = res_lo_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, stall, flush, mthi/mtlo and reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_valid_in;
    logic [5:0]  md_op_in;
    logic        md_read_request_in;
    logic        md_read_hi_in;
    logic [31:0] md_src0_in;
    logic [31:0] md_src1_in;
    logic        md_fire_in;
    logic        md_flush_in;
    logic        md_ready_out;
    logic [31:0] md_rdata_out;
    logic        md_busy_out;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] OpMthi  = 6'b100000;
    localparam logic [5:0] OpMtlo  = 6'b010000;
    localparam logic [5:0] OpMult  = 6'b001000;
    localparam logic [5:0] OpMultu = 6'b000100;
    localparam logic [5:0] OpDiv   = 6'b000010;
    localparam logic [5:0] OpDivu  = 6'b000001;

    mul_div_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .md_valid_in        (md_valid_in),
        .md_op_in           (md_op_in),
        .md_read_request_in (md_read_request_in),
        .md_read_hi_in      (md_read_hi_in),
        .md_src0_in         (md_src0_in),
        .md_src1_in         (md_src1_in),
        .md_fire_in         (md_fire_in),
        .md_flush_in        (md_flush_in),
        .md_ready_out       (md_ready_out),
        .md_rdata_out       (md_rdata_out),
        .md_busy_out        (md_busy_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        md_read_request_in = 1'b1;
        md_read_hi_in = 1'b1;
        #1;
        chk({tag, "_hi"}, md_rdata_out, exp_hi);
        md_read_hi_in = 1'b0;
        #1;
        chk({tag, "_lo"}, md_rdata_out, exp_lo);
        md_read_request_in = 1'b0;
    endtask

    // Issue a mult/div, count edges until ready, fire, then check HI/LO.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int lat;
        md_valid_in = 1'b1;
        md_op_in = op;
        md_src0_in = a;
        md_src1_in = b;
        #1;
        chk({tag, "_ready_low"}, 32'(md_ready_out), 32'd0);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!md_ready_out && lat < 100);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_done"}, 32'(md_busy_out), 32'd1);
        md_fire_in = 1'b1;
        step();
        md_fire_in = 1'b0;
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        chk({tag, "_busy_idle"}, 32'(md_busy_out), 32'd0);
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        rst_n = 1'b0;
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        md_read_request_in = 1'b0;
        md_read_hi_in = 1'b0;
        md_src0_in = 32'd0;
        md_src1_in = 32'd0;
        md_fire_in = 1'b0;
        md_flush_in = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        read_hilo("reset", 32'd0, 32'd0);
        chk("reset_ready", 32'(md_ready_out), 32'd1);
        chk("reset_busy", 32'(md_busy_out), 32'd0);

        // Multiplies
        run_op("mult", OpMult, 32'hFFFF_FFFE, 32'h0000_0003, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", OpMultu, 32'hFFFF_FFFE, 32'h0000_0003, 2, 32'h0000_0002, 32'hFFFF_FFFA);

        // Divides
        run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100_7", OpDivu, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div_min_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_op("divu_by0", OpDivu, 32'h0000_1234, 32'd0, 33, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_neg_by0", OpDiv, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Flush in the middle of a divide
        md_valid_in = 1'b1;
        md_op_in = OpDiv;
        md_src0_in = 32'd100;
        md_src1_in = 32'd3;
        step();
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        for (int i = 0; i < 9; i++) step();
        chk("flush_busy_before", 32'(md_busy_out), 32'd1);
        md_flush_in = 1'b1;
        step();
        md_flush_in = 1'b0;
        chk("flush_busy", 32'(md_busy_out), 32'd0);
        chk("flush_ready", 32'(md_ready_out), 32'd1);
        read_hilo("flush_keep", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("mult_after_flush", OpMult, 32'd5, 32'd6, 2, 32'd0, 32'd30);

        // Result held in DONE while fire is withheld
        md_valid_in = 1'b1;
        md_op_in = OpMult;
        md_src0_in = 32'd7;
        md_src1_in = 32'd9;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 32'(md_ready_out), 32'd1);
            read_hilo("stall_keep", 32'd0, 32'd30);
            step();
        end
        md_fire_in = 1'b1;
        step();
        md_fire_in = 1'b0;
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        read_hilo("stall_commit", 32'd0, 32'd63);

        // Flush and fire together in DONE: no commit
        md_valid_in = 1'b1;
        md_op_in = OpMult;
        md_src0_in = 32'd2;
        md_src1_in = 32'd2;
        step();
        step();
        md_fire_in = 1'b1;
        md_flush_in = 1'b1;
        step();
        md_fire_in = 1'b0;
        md_flush_in = 1'b0;
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        chk("flushfire_busy", 32'(md_busy_out), 32'd0);
        read_hilo("flushfire_keep", 32'd0, 32'd63);

        // mthi / mtlo
        md_valid_in = 1'b1;
        md_op_in = OpMthi;
        md_src0_in = 32'hA5A5_A5A5;
        #1;
        chk("mthi_ready", 32'(md_ready_out), 32'd1);
        md_fire_in = 1'b1;
        step();
        md_op_in = OpMtlo;
        md_src0_in = 32'h5A5A_0F0F;
        read_hilo("mthi", 32'hA5A5_A5A5, 32'd63);
        step();
        md_fire_in = 1'b0;
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        read_hilo("mtlo", 32'hA5A5_A5A5, 32'h5A5A_0F0F);

        // Reset in the middle of a divide
        md_valid_in = 1'b1;
        md_op_in = OpDivu;
        md_src0_in = 32'd50;
        md_src1_in = 32'd5;
        step();
        md_valid_in = 1'b0;
        md_op_in = 6'd0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(md_busy_out), 32'd0);
        read_hilo("midrst", 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
